// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO push arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {IDLE, LOCKED} state_e;

    localparam int unsigned DEF_N         = 4;
    localparam int unsigned DEF_DW        = 32;
    localparam int unsigned DEF_MAX_BURST = 4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] index,
    output logic          valid
);

    int unsigned idx;

    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (32'(ptr) + 32'(k)) % N;
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                index      = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N producers,
// with optional locked bursts of up to MAX_BURST words.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned N         = DEF_N,
    parameter  int unsigned DW        = DEF_DW,
    parameter  int unsigned MAX_BURST = DEF_MAX_BURST,
    localparam int unsigned PW        = clog2(N),
    localparam int unsigned BW        = clog2(MAX_BURST) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    ack,
    output logic            fifo_push,
    output logic [DW-1:0]   fifo_in_data,
    input  logic            fifo_full,
    output logic [PW-1:0]   owner,
    output logic            locked
);

    state_e        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [PW-1:0] sel;

    logic [N-1:0]  pick_grant;
    logic [PW-1:0] pick_idx;
    logic          pick_valid;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .index (pick_idx),
        .valid (pick_valid)
    );

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
        if (32'(i) == N - 1) return '0;
        return i + PW'(1);
    endfunction

    always_comb begin
        ack      = '0;
        sel      = '0;
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        // A full FIFO (or reset) freezes everything: no grant, no state change.
        if (!rst && !fifo_full) begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        ack      = pick_grant;
                        sel      = pick_idx;
                        rr_ptr_d = next_ptr(pick_idx);
                        owner_d  = pick_idx;
                        if (lock[pick_idx] && MAX_BURST > 1) begin
                            state_d = LOCKED;
                            burst_d = BW'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (req[owner_q]) begin
                        ack[owner_q] = 1'b1;
                        sel          = owner_q;
                        rr_ptr_d     = next_ptr(owner_q);
                        if (lock[owner_q] && (32'(burst_q) + 1) < MAX_BURST) begin
                            burst_d = burst_q + BW'(1);
                        end else begin
                            state_d = IDLE;
                            burst_d = '0;
                        end
                    end else begin
                        state_d = IDLE;
                        burst_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_push    = |ack;
        fifo_in_data = fifo_push ? req_data[32'(sel)*DW +: DW] : '0;
        owner        = owner_q;
        locked       = (state_q == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed self-checking bench for fifo_push_arbiter (N=4, DW=32, MAX_BURST=4).
module tb_fifo_push_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic            fifo_push;
    logic [DW-1:0]   fifo_in_data;
    logic            fifo_full;
    logic [1:0]      owner;
    logic            locked;

    int n_cmp;
    int n_fail;

    fifo_push_arbiter #(
        .N         (N),
        .DW        (DW),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .lock         (lock),
        .req_data     (req_data),
        .ack          (ack),
        .fifo_push    (fifo_push),
        .fifo_in_data (fifo_in_data),
        .fifo_full    (fifo_full),
        .owner        (owner),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic test_reset();
        rst       = 1'b1;
        req       = 4'b1111;
        lock      = 4'b0000;
        fifo_full = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (ack !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ack got %b want 0000", ack);
        end
        n_cmp++;
        if (fifo_push !== 1'b0) begin
            n_fail++; $display("FAIL reset_push got %b want 0", fifo_push);
        end
        n_cmp++;
        if (fifo_in_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_data got %h want 0", fifo_in_data);
        end
        n_cmp++;
        if (locked !== 1'b0 || owner !== 2'd0) begin
            n_fail++; $display("FAIL reset_state got locked=%b owner=%0d want 0/0", locked, owner);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ack !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_grant got %b want 0001", ack);
        end
        // Withdraw requests so the next edge carries no transfer and rr_ptr stays 0.
        req = 4'b0000;
        #1;
        n_cmp++;
        if (fifo_push !== 1'b0) begin
            n_fail++; $display("FAIL idle_push got %b want 0", fifo_push);
        end
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_ack;
        logic [31:0] exp_data;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req = 4'b1111;
            #1;
            exp_ack  = 4'b0001 << (k % 4);
            exp_data = 32'hD000_0000 + 32'(k % 4);
            n_cmp++;
            if (ack !== exp_ack) begin
                n_fail++; $display("FAIL fair_ack cyc%0d got %b want %b", k, ack, exp_ack);
            end
            n_cmp++;
            if (fifo_in_data !== exp_data || fifo_push !== 1'b1) begin
                n_fail++;
                $display("FAIL fair_data cyc%0d got %h push=%b want %h push=1",
                         k, fifo_in_data, fifo_push, exp_data);
            end
        end
    endtask

    task automatic test_full_stall();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req       = 4'b0110;
            fifo_full = 1'b1;
            #1;
            n_cmp++;
            if (ack !== 4'b0000 || fifo_push !== 1'b0) begin
                n_fail++; $display("FAIL full_ack cyc%0d got %b push=%b want 0000", k, ack, fifo_push);
            end
        end
        @(negedge clk);
        fifo_full = 1'b0;
        #1;
        n_cmp++;
        if (ack !== 4'b0010) begin
            n_fail++; $display("FAIL full_release1 got %b want 0010", ack);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ack !== 4'b0100 || fifo_in_data !== 32'hD000_0002) begin
            n_fail++; $display("FAIL full_release2 got %b/%h want 0100/d0000002", ack, fifo_in_data);
        end
        @(negedge clk);
        req = 4'b0000;
    endtask

    // rr_ptr is 3 here; scan wraps to requester 0.
    task automatic test_burst_cap();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req  = 4'b0011;
            lock = 4'b0001;
            #1;
            n_cmp++;
            if (ack !== 4'b0001) begin
                n_fail++; $display("FAIL burst_ack cyc%0d got %b want 0001", k, ack);
            end
            n_cmp++;
            if (locked !== (k >= 1)) begin
                n_fail++; $display("FAIL burst_locked cyc%0d got %b want %b", k, locked, (k >= 1));
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ack !== 4'b0010 || locked !== 1'b0) begin
            n_fail++; $display("FAIL burst_cap_end got %b locked=%b want 0010 locked=0", ack, locked);
        end
        @(negedge clk);
        req  = 4'b0000;
        lock = 4'b0000;
    endtask

    // rr_ptr is 2 here, so requester 2 wins and locks.
    task automatic test_owner_drop();
        @(negedge clk);
        req  = 4'b0111;
        lock = 4'b0100;
        #1;
        n_cmp++;
        if (ack !== 4'b0100 || locked !== 1'b0) begin
            n_fail++; $display("FAIL drop_first got %b locked=%b want 0100 locked=0", ack, locked);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ack !== 4'b0100 || locked !== 1'b1 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL drop_second got %b locked=%b owner=%0d want 0100 1 2", ack, locked, owner);
        end
        @(negedge clk);
        req = 4'b1011;
        #1;
        n_cmp++;
        if (ack !== 4'b0000 || fifo_push !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_ignore got %b push=%b locked=%b want 0000 0 1", ack, fifo_push, locked);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ack !== 4'b1000 || locked !== 1'b0) begin
            n_fail++; $display("FAIL drop_next got %b locked=%b want 1000 locked=0", ack, locked);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ack !== 4'b0001) begin
            n_fail++; $display("FAIL drop_wrap got %b want 0001", ack);
        end
        @(negedge clk);
        req  = 4'b0000;
        lock = 4'b0000;
    endtask

    // rr_ptr is 1 here; requester 1 locks, stalls on full, then reset hits mid-burst.
    task automatic test_async_reset();
        @(negedge clk);
        req  = 4'b0010;
        lock = 4'b0010;
        #1;
        n_cmp++;
        if (ack !== 4'b0010) begin
            n_fail++; $display("FAIL ar_first got %b want 0010", ack);
        end
        @(negedge clk);
        fifo_full = 1'b1;
        #1;
        n_cmp++;
        if (ack !== 4'b0000 || locked !== 1'b1) begin
            n_fail++; $display("FAIL ar_stall got %b locked=%b want 0000 locked=1", ack, locked);
        end
        @(negedge clk);
        fifo_full = 1'b0;
        #1;
        n_cmp++;
        if (ack !== 4'b0010 || locked !== 1'b1) begin
            n_fail++; $display("FAIL ar_resume got %b locked=%b want 0010 locked=1", ack, locked);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ack !== 4'b0000 || fifo_push !== 1'b0 || locked !== 1'b0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL ar_reset got %b push=%b locked=%b owner=%0d want 0000 0 0 0",
                     ack, fifo_push, locked, owner);
        end
        @(negedge clk);
        rst  = 1'b0;
        req  = 4'b1111;
        lock = 4'b0000;
        #1;
        n_cmp++;
        if (ack !== 4'b0001 || locked !== 1'b0) begin
            n_fail++; $display("FAIL ar_after got %b locked=%b want 0001 locked=0", ack, locked);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        req    = '0;
        lock   = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hD000_0000 + 32'(i);
        test_reset();
        test_fairness();
        test_full_stall();
        test_burst_cap();
        test_owner_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
